// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command decoder.
//   state_t       : command parser states
//   ASCII_*       : command and whitespace byte codes
package uart_cmd_pkg;

  localparam int unsigned BYTE_WIDTH   = 8;
  localparam int unsigned NIBBLE_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEX_HI = 2'd1,
    HEX_LO = 2'd2,
    TERM   = 2'd3
  } state_t;

  localparam logic [BYTE_WIDTH-1:0] ASCII_R_UP = 8'h52;
  localparam logic [BYTE_WIDTH-1:0] ASCII_R_LO = 8'h72;
  localparam logic [BYTE_WIDTH-1:0] ASCII_G_UP = 8'h47;
  localparam logic [BYTE_WIDTH-1:0] ASCII_G_LO = 8'h67;
  localparam logic [BYTE_WIDTH-1:0] ASCII_B_UP = 8'h42;
  localparam logic [BYTE_WIDTH-1:0] ASCII_B_LO = 8'h62;
  localparam logic [BYTE_WIDTH-1:0] ASCII_L_UP = 8'h4C;
  localparam logic [BYTE_WIDTH-1:0] ASCII_CR   = 8'h0D;
  localparam logic [BYTE_WIDTH-1:0] ASCII_LF   = 8'h0A;
  localparam logic [BYTE_WIDTH-1:0] ASCII_SP   = 8'h20;

endpackage

// File: rtl/hex_nibble_decode.sv
// Combinational ASCII hex digit decoder.
//   ascii  : input byte
//   nibble : value of the digit (0 when not a hex digit)
//   is_hex : 1 when ascii is 0-9, A-F or a-f
module hex_nibble_decode
  import uart_cmd_pkg::*;
(
  input  logic [BYTE_WIDTH-1:0]   ascii,
  output logic [NIBBLE_WIDTH-1:0] nibble,
  output logic                    is_hex
);

  always_comb begin
    nibble = '0;
    is_hex = 1'b0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      nibble = NIBBLE_WIDTH'(ascii - 8'h30);
      is_hex = 1'b1;
    end else if (ascii >= 8'h41 && ascii <= 8'h46) begin
      nibble = NIBBLE_WIDTH'(ascii - 8'h37);
      is_hex = 1'b1;
    end else if (ascii >= 8'h61 && ascii <= 8'h66) begin
      nibble = NIBBLE_WIDTH'(ascii - 8'h57);
      is_hex = 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes ASCII bytes from a UART receiver into RGB channel enables and a
// global brightness level. Commands: R/r G/g B/b set/clear a channel,
// "L<hex><hex><CR|LF>" loads brightness. CR, LF and space are ignored idle.
//   clk_in, reset        : clock, asynchronous active-high reset
//   rx_data/valid/invalid: received byte, strobe, framing error
//   enable_red/green/blue: channel enables
//   brightness           : brightness level
//   cmd_ack / cmd_err    : one-cycle applied / rejected pulses
// Optional macro UART_CMD_TIMEOUT_EN adds an inter-byte timeout that aborts
// partial commands after TIMEOUT_CYCLES idle cycles.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned BRIGHT_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5320000,
  parameter int unsigned TIMEOUT_WIDTH  = 23
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [BYTE_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  input  logic                    rx_invalid,
  output logic                    enable_red,
  output logic                    enable_green,
  output logic                    enable_blue,
  output logic [BRIGHT_WIDTH-1:0] brightness,
  output logic                    cmd_ack,
  output logic                    cmd_err
);

  // Elaboration guard: brightness is two hex digits and the counter must hold the timeout.
  if (BRIGHT_WIDTH != 8 || TIMEOUT_CYCLES < 2 || $clog2(TIMEOUT_CYCLES) > TIMEOUT_WIDTH) begin : g_param_check
    $error("uart_cmd_decoder: unsupported parameter combination");
  end

  state_t                  state, state_nxt;
  logic [NIBBLE_WIDTH-1:0] hi_nib, hi_nib_nxt;
  logic [NIBBLE_WIDTH-1:0] lo_nib, lo_nib_nxt;
  logic                    red_nxt, green_nxt, blue_nxt;
  logic [BRIGHT_WIDTH-1:0] bright_nxt;
  logic                    ack_nxt, err_nxt;

  logic [NIBBLE_WIDTH-1:0] dec_nibble;
  logic                    dec_is_hex;

`ifdef UART_CMD_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt, tmo_cnt_nxt;
  logic                     tmo_expired;
`endif

  hex_nibble_decode u_hex (
    .ascii  (rx_data),
    .nibble (dec_nibble),
    .is_hex (dec_is_hex)
  );

  // State and output registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      hi_nib       <= '0;
      lo_nib       <= '0;
      enable_red   <= 1'b1;
      enable_green <= 1'b1;
      enable_blue  <= 1'b1;
      brightness   <= '1;
      cmd_ack      <= 1'b0;
      cmd_err      <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      state        <= state_nxt;
      hi_nib       <= hi_nib_nxt;
      lo_nib       <= lo_nib_nxt;
      enable_red   <= red_nxt;
      enable_green <= green_nxt;
      enable_blue  <= blue_nxt;
      brightness   <= bright_nxt;
      cmd_ack      <= ack_nxt;
      cmd_err      <= err_nxt;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_cnt      <= tmo_cnt_nxt;
`endif
    end
  end

`ifdef UART_CMD_TIMEOUT_EN
  // Counter only runs mid-command; any received byte restarts the window.
  always_comb begin
    tmo_expired = (state != IDLE) && (tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
    tmo_cnt_nxt = tmo_cnt + TIMEOUT_WIDTH'(1);
    if (rx_valid || state == IDLE || tmo_expired) begin
      tmo_cnt_nxt = '0;
    end
  end
`endif

  // Next-state and output decode.
  always_comb begin
    state_nxt  = state;
    hi_nib_nxt = hi_nib;
    lo_nib_nxt = lo_nib;
    red_nxt    = enable_red;
    green_nxt  = enable_green;
    blue_nxt   = enable_blue;
    bright_nxt = brightness;
    ack_nxt    = 1'b0;
    err_nxt    = 1'b0;

    if (rx_valid) begin
      if (rx_invalid) begin
        // Framing errors abort whatever was in progress.
        err_nxt   = 1'b1;
        state_nxt = IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            unique case (rx_data)
              ASCII_R_UP: begin red_nxt   = 1'b1; ack_nxt = 1'b1; end
              ASCII_R_LO: begin red_nxt   = 1'b0; ack_nxt = 1'b1; end
              ASCII_G_UP: begin green_nxt = 1'b1; ack_nxt = 1'b1; end
              ASCII_G_LO: begin green_nxt = 1'b0; ack_nxt = 1'b1; end
              ASCII_B_UP: begin blue_nxt  = 1'b1; ack_nxt = 1'b1; end
              ASCII_B_LO: begin blue_nxt  = 1'b0; ack_nxt = 1'b1; end
              ASCII_L_UP: state_nxt = HEX_HI;
              ASCII_CR, ASCII_LF, ASCII_SP: ;
              default:    err_nxt = 1'b1;
            endcase
          end
          HEX_HI: begin
            if (dec_is_hex) begin
              hi_nib_nxt = dec_nibble;
              state_nxt  = HEX_LO;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end
          end
          HEX_LO: begin
            if (dec_is_hex) begin
              lo_nib_nxt = dec_nibble;
              state_nxt  = TERM;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end
          end
          TERM: begin
            if (rx_data == ASCII_CR || rx_data == ASCII_LF) begin
              bright_nxt = BRIGHT_WIDTH'({hi_nib, lo_nib});
              ack_nxt    = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
            state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
`ifdef UART_CMD_TIMEOUT_EN
    else if (tmo_expired) begin
      // A byte arriving on the expiry cycle wins, hence the else.
      err_nxt   = 1'b1;
      state_nxt = IDLE;
    end
`endif
  end

endmodule
